// File: rtl/pc_fetch_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctl
// Purpose  : Program counter and fetch sequencing with IDLE/RUN/HALTED control,
//            absolute or PC-relative jumps through the branch-target table.
//            Optional return stack enabled by macro PC_RETURN_STACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctl #(
    parameter int D        = 10,
    parameter int RS_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         halt_i,
    input  logic         stall_i,
    input  logic         branch_en_i,
    input  logic         taken_i,
    input  logic         rel_i,
    input  logic [3:0]   lut_idx_i,
    input  logic         call_i,
    input  logic         ret_i,
    output logic [3:0]   lut_addr_o,
    input  logic [D-1:0] target_i,
    output logic [D-1:0] pc_o,
    output logic         running_o,
    output logic         done_o,
    output logic         rs_err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         w_push_req, w_pop_req;
    logic         w_rs_empty;
    logic [D-1:0] w_rs_top;
    logic [D-1:0] w_pc_inc;

`ifdef PC_RETURN_STACK_EN
    localparam bit RS_EN = 1'b1;
    localparam int PW    = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CW    = $clog2(RS_DEPTH + 1);

    logic [D-1:0]  rs_mem_q [RS_DEPTH];
    logic [PW-1:0] rs_ptr_q;   // next free slot; wraps so a full push lands on the oldest entry
    logic [CW-1:0] rs_cnt_q;
    logic          rs_err_q;
    logic [PW-1:0] w_ptr_inc, w_ptr_dec;
    logic          w_rs_full;

    always_comb begin
        w_ptr_inc = (rs_ptr_q == PW'(RS_DEPTH - 1)) ? '0 : rs_ptr_q + 1'b1;
        w_ptr_dec = (rs_ptr_q == '0) ? PW'(RS_DEPTH - 1) : rs_ptr_q - 1'b1;
    end

    assign w_rs_full  = (rs_cnt_q == CW'(RS_DEPTH));
    assign w_rs_empty = (rs_cnt_q == '0);
    assign w_rs_top   = rs_mem_q[w_ptr_dec];
    assign rs_err_o   = rs_err_q;

    always_ff @(posedge clk_i) begin
        if (w_push_req) begin
            rs_mem_q[rs_ptr_q] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rs_ptr_q <= '0;
            rs_cnt_q <= '0;
            rs_err_q <= 1'b0;
        end else if (w_pop_req) begin
            if (w_rs_empty) begin
                rs_err_q <= 1'b1;
            end else begin
                rs_ptr_q <= w_ptr_dec;
                rs_cnt_q <= rs_cnt_q - 1'b1;
            end
        end else if (w_push_req) begin
            rs_ptr_q <= w_ptr_inc;
            if (w_rs_full) begin
                rs_err_q <= 1'b1;
            end else begin
                rs_cnt_q <= rs_cnt_q + 1'b1;
            end
        end
    end
`else
    localparam bit RS_EN = 1'b0;
    logic unused_cfg;

    assign w_rs_empty = 1'b1;
    assign w_rs_top   = '0;
    assign rs_err_o   = 1'b0;
    assign unused_cfg = w_push_req ^ w_pop_req ^ (RS_DEPTH > 0);
`endif

    assign w_pc_inc   = pc_q + 1'b1;
    assign lut_addr_o = lut_idx_i;
    assign pc_o       = pc_q;
    assign running_o  = (state_q == S_RUN);
    assign done_o     = (state_q == S_HALTED);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        w_push_req = 1'b0;
        w_pop_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start_i) begin
                    pc_d = '0;
                end else if (halt_i) begin
                    state_d = S_HALTED;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (ret_i) begin
                    // Without a stack (or with it empty) a return simply falls through.
                    w_pop_req = RS_EN;
                    pc_d      = w_rs_empty ? w_pc_inc : w_rs_top;
                end else if (branch_en_i && taken_i) begin
                    w_push_req = call_i & RS_EN;
                    pc_d       = rel_i ? (pc_q + target_i) : target_i;
                end else begin
                    pc_d = w_pc_inc;
                end
            end
            S_HALTED: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctl
// Purpose  : Self-checking bench for pc_fetch_ctl; expected pc/state pushed to a
//            scoreboard queue at drive time and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctl;

    localparam int D = 10;

    logic         clk_i = 1'b0;
    logic         reset_i, start_i, halt_i, stall_i, branch_en_i, taken_i, rel_i;
    logic         call_i, ret_i;
    logic [3:0]   lut_idx_i, lut_addr_o;
    logic [D-1:0] target_i, pc_o;
    logic         running_o, done_o, rs_err_o;

    logic [D-1:0] tbl [16];
    logic         exp_err;

    typedef struct {
        string        tag;
        logic [D-1:0] pc;
        logic         run;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    always_comb target_i = tbl[lut_addr_o];

    pc_fetch_ctl #(.D(D), .RS_DEPTH(4)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .halt_i      (halt_i),
        .stall_i     (stall_i),
        .branch_en_i (branch_en_i),
        .taken_i     (taken_i),
        .rel_i       (rel_i),
        .lut_idx_i   (lut_idx_i),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .lut_addr_o  (lut_addr_o),
        .target_i    (target_i),
        .pc_o        (pc_o),
        .running_o   (running_o),
        .done_o      (done_o),
        .rs_err_o    (rs_err_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare.
    task automatic apply(input string tag, input logic st, hl, sl, br, tk, rl,
                         input logic [3:0] idx, input logic cl, rt,
                         input logic [D-1:0] epc, input logic erun, edone);
        exp_t e;
        exp_t o;
        start_i     = st;
        halt_i      = hl;
        stall_i     = sl;
        branch_en_i = br;
        taken_i     = tk;
        rel_i       = rl;
        lut_idx_i   = idx;
        call_i      = cl;
        ret_i       = rt;
        #1;
        if (br) check_val({tag, ".lut_addr"}, 32'(lut_addr_o), 32'(idx));
        e.tag  = tag;
        e.pc   = epc;
        e.run  = erun;
        e.done = edone;
        e.err  = exp_err;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        o = sb.pop_front();
        check_val({o.tag, ".pc"},      32'(pc_o),      32'(o.pc));
        check_val({o.tag, ".running"}, 32'(running_o), 32'(o.run));
        check_val({o.tag, ".done"},    32'(done_o),    32'(o.done));
        check_val({o.tag, ".rs_err"},  32'(rs_err_o),  32'(o.err));
    endtask

    task automatic step(input string tag, input logic [D-1:0] epc);
        apply(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, epc, 1'b1, 1'b0);
    endtask

    task automatic jump(input string tag, input logic rl, input logic [3:0] idx,
                        input logic cl, input logic [D-1:0] epc);
        apply(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rl, idx, cl, 1'b0, epc, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '0;
        tbl[2]  = 10'd80;
        tbl[3]  = 10'd121;
        tbl[5]  = 10'd1023;
        tbl[7]  = 10'd1020;
        tbl[8]  = 10'd1018;
        tbl[9]  = 10'd20;
        tbl[10] = 10'd10;
        tbl[11] = 10'd8;
        tbl[12] = 10'd7;
        exp_err = 1'b0;

        reset_i = 1'b1;
        apply("reset", 1, 0, 0, 1, 1, 0, 4'd2, 0, 0, 10'd0, 0, 0);
        reset_i = 1'b0;
        apply("idle_ignore", 0, 0, 0, 1, 1, 0, 4'd2, 0, 0, 10'd0, 0, 0);

        apply("start", 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 10'd0, 1, 0);
        for (int i = 1; i <= 5; i++) step("inc", 10'(i));
        jump("abs_idx2", 0, 4'd2, 0, 10'd80);

        apply("restart", 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 10'd0, 1, 0);
        for (int i = 1; i <= 4; i++) step("inc_b", 10'(i));
        jump("rel_minus1", 1, 4'd5, 0, 10'd3);
        jump("abs_1020", 0, 4'd7, 0, 10'd1020);
        jump("rel_wrap", 1, 4'd9, 0, 10'd16);
        apply("not_taken", 0, 0, 0, 1, 0, 0, 4'd2, 0, 0, 10'd17, 1, 0);

        jump("abs_10", 0, 4'd10, 0, 10'd10);
        apply("prio_halt", 0, 1, 1, 1, 1, 0, 4'd2, 0, 0, 10'd10, 0, 1);
        apply("halted_ign", 0, 0, 0, 1, 1, 0, 4'd2, 0, 1, 10'd10, 0, 1);
        apply("halted_hold", 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 10'd10, 0, 1);
        apply("halted_start", 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 10'd0, 1, 0);
        apply("stall_drop_br", 0, 0, 1, 1, 1, 0, 4'd2, 0, 0, 10'd0, 1, 0);
        apply("start_over_br", 1, 0, 0, 1, 1, 0, 4'd2, 0, 0, 10'd0, 1, 0);

        jump("abs_1018", 0, 4'd8, 0, 10'd1018);
        for (int i = 1019; i <= 1023; i++) step("inc_hi", 10'(i));
        step("inc_wrap", 10'd0);
        step("inc_after_wrap", 10'd1);
        for (int i = 0; i < 3; i++)
            apply("stall", 0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 10'd1, 1, 0);
        step("after_stall", 10'd2);

`ifdef PC_RETURN_STACK_EN
        jump("to_7", 0, 4'd12, 0, 10'd7);
        jump("call_121", 0, 4'd3, 1, 10'd121);
        apply("ret_to_8", 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 10'd8, 1, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) exp_err = 1'b1;
            jump("nest_call", 0, 4'd3, 1, 10'd121);
        end
        for (int i = 0; i < 4; i++)
            apply("nest_ret", 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 10'd122, 1, 0);
        apply("ret_empty", 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 10'd123, 1, 0);
`else
        jump("to_8", 0, 4'd11, 0, 10'd8);
        apply("ret_noop", 0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 10'd9, 1, 0);
        jump("call_plain", 0, 4'd3, 1, 10'd121);
        apply("ret_over_br", 0, 0, 0, 1, 1, 0, 4'd2, 0, 1, 10'd122, 1, 0);
`endif

        reset_i = 1'b1;
        exp_err = 1'b0;
        apply("reset_run", 1, 0, 0, 1, 1, 0, 4'd2, 0, 0, 10'd0, 0, 0);
        reset_i = 1'b0;
        apply("start_final", 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 10'd0, 1, 0);
        step("inc_final", 10'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctl.md
# pc_fetch_ctl

Program-counter and fetch-sequencing controller; the requesting end of the branch-target lookup table. Holds the D-bit program counter, drives the 4-bit target-table index, consumes the returned D-bit target, and applies it as an absolute or PC-relative (two's-complement, modulo 2^D) jump. Sits between the instruction decoder and instruction memory, with a run/halt FSM the test harness uses to start and finish a program.

## Interface
- D, 10, PC and target width; instruction memory depth is 2^D.
- RS_DEPTH, 4, return-stack entries (used only with PC_RETURN_STACK_EN).
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  begin or restart program execution.
- halt  input  1  decoder saw the halt instruction.
- stall  input  1  hold PC this cycle.
- branch_en  input  1  current instruction is a branch.
- taken  input  1  branch condition true.
- rel  input  1  1 = relative jump, 0 = absolute jump.
- lut_idx  input  4  target-table index from the instruction.
- call  input  1  branch is a call (push return address).
- ret  input  1  current instruction is a return.
- lut_addr  output  4  index to target table.
- target  input  D  target-table data for lut_addr.
- pc  output  D  current program counter / instruction address.
- running  output  1  FSM in RUN.
- done  output  1  program has halted.
- rs_err  output  1  sticky return-stack overflow/underflow flag.

## Operation
- lut_addr = lut_idx, combinational; target is combinational from the table and sampled in the same cycle.
- FSM states: IDLE, RUN, HALTED. Reset → IDLE.
- IDLE: pc held at 0. start → pc<=0, RUN.
- RUN, priority per cycle, highest first: start (pc<=0, stay RUN), halt (→HALTED, pc held), stall (pc held), ret, taken branch, increment.
- Taken branch (branch_en & taken): rel=0 → pc<=target; rel=1 → pc<=(pc+target) mod 2^D, target treated as signed D-bit (1023 = −1 at D=10).
- branch_en & !taken → pc<=pc+1.
- Increment wraps: pc=2^D−1 → 0.
- HALTED: pc frozen; start → pc<=0, RUN; all other inputs ignored.
- running=1 exactly in RUN; done=1 exactly in HALTED.
- Inputs other than start and Reset are ignored outside RUN.

## Timing
- Reset values: pc=0, state IDLE, running=0, done=0, rs_err=0, stack pointer 0. Reset wins over every other input.
- Jump latency one cycle: the branch presented in cycle n makes pc=new value in cycle n+1; no bubble.
- stall & taken branch same cycle: the branch is dropped; the decoder re-presents it.
- halt & branch same cycle: halt wins, pc unchanged.
- Reset mid-RUN: next cycle IDLE, pc=0, stack cleared.

## Configuration
- Macro PC_RETURN_STACK_EN.
- Defined: RS_DEPTH-entry return stack. Taken branch with call=1 pushes pc+1 (mod 2^D) and jumps. ret pops into pc. Push when full overwrites the oldest entry and sets rs_err. Pop when empty → pc<=pc+1 and sets rs_err. call and ret in the same cycle: ret wins and no push occurs.
- Undefined: no stack storage. call is treated as a plain branch. ret is treated as a non-branch (pc+1). rs_err is tied to 0.

## Test plan
- Reset, then start → pc=0,1,2,3 on successive cycles; running=1, done=0.
- Absolute branch: table idx 2=80; at pc=5, branch_en=taken=1, rel=0, lut_idx=2 → lut_addr=2 the same cycle, pc=80 next cycle.
- Relative branch: idx 5=1023; at pc=4, rel=1, lut_idx=5 → pc=3. Idx 9=20 at pc=1020 → pc=16 (wrap).
- Priority: at pc=10, halt, stall and a taken branch together → HALTED, pc=10, done=1; later start → pc=0, RUN.
- Increment wrap: run to pc=1023 (D=10) → next pc=0. stall for 3 cycles → pc constant.
- PC_RETURN_STACK_EN: call idx 3 (121) from pc=7 → pc=121; ret → pc=8. Five nested calls → rs_err=1. With the macro undefined, ret at pc=8 → pc=9.
